// File: rtl/illum_ssd_pkg.sv
// Shared definitions for the seven-segment frame capture block.
//   - Active-low glyph constants {g,f,e,d,c,b,a} for hex digits, blank and
//     the encrypted-digit symbol.
//   - Two-bit glyph class codes.
//   - Capture FSM state encoding.
package illum_ssd_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  // Only segment g lit: the symbol the game shows for an encrypted digit.
  localparam logic [6:0] GLYPH_ENC   = 7'b0111111;

  localparam logic [1:0] CLS_HEX     = 2'b00;
  localparam logic [1:0] CLS_BLANK   = 2'b01;
  localparam logic [1:0] CLS_ENC     = 2'b10;
  localparam logic [1:0] CLS_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } cap_state_t;

endpackage

// File: rtl/ssd_glyph_decode.sv
// Combinational decode of one active-low seven-segment glyph.
// Ports:
//   i_glyph  [6:0]  active-low segments {g,f,e,d,c,b,a}
//   o_class  [1:0]  00 hex, 01 blank, 10 encrypted, 11 illegal
//   o_nibble [3:0]  digit value for class 00, otherwise 0
// Configuration macro: SSD_ENC_DECODE_EN -- when defined the encrypted-digit
// glyph decodes as class 10; when undefined it falls through to illegal.
module ssd_glyph_decode
  import illum_ssd_pkg::*;
(
  input  logic [6:0] i_glyph,
  output logic [1:0] o_class,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_class  = CLS_HEX;
    o_nibble = 4'h0;
    case (i_glyph)
      GLYPH_0:     o_nibble = 4'h0;
      GLYPH_1:     o_nibble = 4'h1;
      GLYPH_2:     o_nibble = 4'h2;
      GLYPH_3:     o_nibble = 4'h3;
      GLYPH_4:     o_nibble = 4'h4;
      GLYPH_5:     o_nibble = 4'h5;
      GLYPH_6:     o_nibble = 4'h6;
      GLYPH_7:     o_nibble = 4'h7;
      GLYPH_8:     o_nibble = 4'h8;
      GLYPH_9:     o_nibble = 4'h9;
      GLYPH_A:     o_nibble = 4'hA;
      GLYPH_B:     o_nibble = 4'hB;
      GLYPH_C:     o_nibble = 4'hC;
      GLYPH_D:     o_nibble = 4'hD;
      GLYPH_E:     o_nibble = 4'hE;
      GLYPH_F:     o_nibble = 4'hF;
      GLYPH_BLANK: o_class  = CLS_BLANK;
`ifdef SSD_ENC_DECODE_EN
      GLYPH_ENC:   o_class  = CLS_ENC;
`endif
      default:     o_class  = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/ssd_frame_capture.sv
// Receive end of the 8-digit seven-segment display bus. Samples the 56
// segment lines, waits for the frame to settle, decodes each glyph and
// presents every new stable frame to a consumer.
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   hex_in      [55:0] {HEX7..HEX0}, each active-low {g,f,e,d,c,b,a}
//   cap_ack     consumer accepts the held frame
//   cap_valid   a captured frame is held on cap_*
//   cap_digits  [31:0] decoded nibbles, [31:28]=HEX7 .. [3:0]=HEX0
//   cap_class   [15:0] 2-bit class per digit, same order
//   drop_cnt    [DROP_W-1:0] saturating count of stable distinct frames
//               missed while a frame was held
//   state_dbg   [1:0] current FSM state (debug visibility)
// Handshake: cap_valid rises with the frame and stays up, with cap_* frozen,
// until cap_ack is sampled high; cap_valid then drops for at least one cycle.
// cap_ack while cap_valid is low has no effect.
// Configuration macro: SSD_ENC_DECODE_EN (handled in ssd_glyph_decode).
module ssd_frame_capture
  import illum_ssd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DROP_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [55:0]       hex_in,
  input  logic              cap_ack,
  output logic              cap_valid,
  output logic [31:0]       cap_digits,
  output logic [15:0]       cap_class,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [1:0]        state_dbg
);

  localparam logic [7:0]        STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [55:0]       r_hex_q;
  logic [7:0]        r_stab_cnt;
  logic [7:0]        w_stab_nxt;
  logic              r_stab_new;
  logic [55:0]       r_last;
  logic              r_last_vld;
  cap_state_t        r_state;
  logic              r_cap_valid;
  logic [31:0]       r_cap_digits;
  logic [15:0]       r_cap_class;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [31:0]       w_digits;
  logic [15:0]       w_class;
  logic              w_stable;
  logic              w_distinct;

  // The counter is compared against the incoming sample so it clears on the
  // same edge that loads a new value into r_hex_q; this keeps capture latency
  // at STABLE_CYCLES+1 edges after the first sample.
  always_comb begin
    w_stab_nxt = r_stab_cnt;
    if (hex_in != r_hex_q)
      w_stab_nxt = 8'd0;
    else if (r_stab_cnt != STAB_MAX)
      w_stab_nxt = r_stab_cnt + 8'd1;
  end

  assign w_stable   = (r_stab_cnt == STAB_MAX);
  // An empty last-captured register makes any stable frame distinct.
  assign w_distinct = !r_last_vld || (r_hex_q != r_last);

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_dec
      ssd_glyph_decode u_dec (
        .i_glyph  (r_hex_q[7*g +: 7]),
        .o_class  (w_class[2*g +: 2]),
        .o_nibble (w_digits[4*g +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hex_q    <= '0;
      r_stab_cnt <= '0;
      r_stab_new <= 1'b0;
    end else begin
      r_hex_q    <= hex_in;
      r_stab_cnt <= w_stab_nxt;
      // One-cycle marker: the counter reached its limit on this edge, so each
      // stable run is reported exactly once to the overrun logic.
      r_stab_new <= (w_stab_nxt == STAB_MAX) && (r_stab_cnt != STAB_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cap_valid  <= 1'b0;
      r_cap_digits <= '0;
      r_cap_class  <= '0;
      r_last       <= '0;
      r_last_vld   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_stable)
            r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_stable) begin
            if (w_distinct) begin
              r_cap_digits <= w_digits;
              r_cap_class  <= w_class;
              r_last       <= r_hex_q;
              r_last_vld   <= 1'b1;
              r_cap_valid  <= 1'b1;
              r_state      <= ST_HOLD;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (cap_ack) begin
            r_cap_valid <= 1'b0;
            r_state     <= w_distinct ? ST_SETTLE : ST_IDLE;
          end else if (r_stab_new && w_distinct && (r_drop_cnt != DROP_MAX)) begin
            // A frame that settles in the same cycle as the ack is not lost:
            // it is captured right after the ack instead.
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cap_valid  = r_cap_valid;
  assign cap_digits = r_cap_digits;
  assign cap_class  = r_cap_class;
  assign drop_cnt   = r_drop_cnt;
  assign state_dbg  = r_state;

endmodule
